// File: rtl/spi_mem_req.sv
`default_nettype none
// ============================================================================
// Module      : spi_mem_req
// Description : Request FIFO and four-phase en/valid sequencer in front of the
//               FRAM SPI engine. Optional macro SPI_MEM_REQ_WRITE_ACK_EN makes
//               writes return a response as well as reads.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_mem_req #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_wr,
    input  logic [5:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_wr,
    output logic [5:0] rsp_addr,
    output logic [7:0] rsp_data,
    output logic       mem_wr_en,
    output logic [5:0] mem_addr,
    output logic [7:0] mem_wr_data,
    input  logic [7:0] mem_rd_data,
    output logic       mem_en,
    input  logic       mem_valid,
    output logic       busy
);
    localparam int c_aw = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
`ifdef SPI_MEM_REQ_WRITE_ACK_EN
    localparam bit c_write_ack = 1'b1;
`else
    localparam bit c_write_ack = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_RELEASE = 2'd2,
        S_RESP    = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_fifo_wr   [FIFO_DEPTH];
    logic [5:0]        r_fifo_addr [FIFO_DEPTH];
    logic [7:0]        r_fifo_data [FIFO_DEPTH];
    logic [c_aw:0]     r_wptr;
    logic [c_aw:0]     r_rptr;
    logic [c_aw-1:0]   w_widx;
    logic [c_aw-1:0]   w_ridx;
    logic              w_empty;
    logic              w_full;
    logic              w_push;
    logic              w_pop;

    assign w_widx    = r_wptr[c_aw-1:0];
    assign w_ridx    = r_rptr[c_aw-1:0];
    assign w_empty   = (r_wptr == r_rptr);
    // Same index with differing wrap bits means the write side lapped the read side.
    assign w_full    = (r_wptr[c_aw] != r_rptr[c_aw]) && (w_widx == w_ridx);
    assign req_ready = !w_full;
    assign w_push    = req_valid && !w_full;
    assign w_pop     = (r_state == S_IDLE) && !w_empty && !mem_valid;
    assign busy      = !w_empty || (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_wr[w_widx]   <= req_wr;
            r_fifo_addr[w_widx] <= req_addr;
            r_fifo_data[w_widx] <= req_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
        end else if (w_push) begin
            r_wptr <= r_wptr + (c_aw+1)'(1);
        end
    end

`ifdef SPI_MEM_REQ_WRITE_ACK_EN
    logic r_rsp_wr;
    assign rsp_wr = r_rsp_wr;
`else
    assign rsp_wr = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rptr      <= '0;
            mem_en      <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
            rsp_valid   <= 1'b0;
            rsp_addr    <= '0;
            rsp_data    <= '0;
`ifdef SPI_MEM_REQ_WRITE_ACK_EN
            r_rsp_wr    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    // The command register only loads here, keeping mem_* stable for the whole handshake.
                    if (w_pop) begin
                        r_rptr      <= r_rptr + (c_aw+1)'(1);
                        mem_wr_en   <= r_fifo_wr[w_ridx];
                        mem_addr    <= r_fifo_addr[w_ridx];
                        mem_wr_data <= r_fifo_data[w_ridx];
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (mem_valid) begin
                        mem_en   <= 1'b0;
                        rsp_addr <= mem_addr;
                        rsp_data <= mem_wr_en ? mem_wr_data : mem_rd_data;
`ifdef SPI_MEM_REQ_WRITE_ACK_EN
                        r_rsp_wr <= mem_wr_en;
`endif
                        r_state  <= S_RELEASE;
                    end else begin
                        mem_en <= 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (!mem_valid) begin
                        if (!mem_wr_en || c_write_ack) begin
                            rsp_valid <= 1'b1;
                            r_state   <= S_RESP;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_spi_mem_req.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_mem_req
// Description : Bench for spi_mem_req with a behavioural FRAM engine model and
//               an in-order response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_mem_req;
    localparam int DEPTH = 4;
`ifdef SPI_MEM_REQ_WRITE_ACK_EN
    localparam bit ACK = 1'b1;
`else
    localparam bit ACK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid, req_ready, req_wr;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_ready, rsp_wr;
    logic [5:0] rsp_addr;
    logic [7:0] rsp_data;
    logic       mem_wr_en, mem_en, mem_valid, busy;
    logic [5:0] mem_addr;
    logic [7:0] mem_wr_data, mem_rd_data;

    spi_mem_req #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_addr(rsp_addr), .rsp_data(rsp_data),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data), .mem_en(mem_en), .mem_valid(mem_valid),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- behavioural FRAM engine ----------------
    logic [7:0] emem [64];
    int   lat_lo = 1, lat_hi = 3, fall_lo = 0, fall_hi = 2;
    int   e_phase = 0;   // 0 wait en, 1 access latency, 2 valid high, 3 valid fall delay
    int   e_cnt;
    logic       e_wr;
    logic [5:0] e_addr;
    logic [7:0] e_wd;

    always @(posedge clk) begin
        if (rst) begin
            mem_valid <= 1'b0;
            e_phase = 0;
        end else begin
            case (e_phase)
                0: if (mem_en) begin
                    e_wr = mem_wr_en; e_addr = mem_addr; e_wd = mem_wr_data;
                    e_cnt = $urandom_range(lat_hi, lat_lo);
                    e_phase = 1;
                end
                1: if (e_cnt > 0) e_cnt--;
                   else begin
                       if (e_wr) emem[e_addr] = e_wd;
                       else mem_rd_data <= emem[e_addr];
                       mem_valid <= 1'b1;
                       e_phase = 2;
                   end
                2: if (!mem_en) begin
                    e_cnt = $urandom_range(fall_hi, fall_lo);
                    e_phase = 3;
                end
                default: if (e_cnt > 0) e_cnt--;
                   else begin
                       mem_valid <= 1'b0;
                       e_phase = 0;
                   end
            endcase
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (e_phase != 0)
                check_eq("cmd_stable", 32'({mem_wr_en, mem_addr, mem_wr_data}), 32'({e_wr, e_addr, e_wd}));
            if (e_phase == 1) check_eq("en_held", 32'(mem_en), 1);
            if (e_phase == 3) check_eq("en_low_until_valid_fall", 32'(mem_en), 0);
        end
    end

    // ---------------- reference model and response scoreboard ----------------
    typedef struct packed {
        logic       wr;
        logic [5:0] addr;
        logic [7:0] data;
    } rsp_t;

    logic [7:0] ref_mem [64];
    rsp_t expq[$];
    bit   rdy_force = 1'b1;
    bit   rdy_val   = 1'b1;
    int   rsp_hi = 0, n_rsp = 0, n_acc = 0;

    always @(negedge clk) begin
        rsp_ready = rdy_force ? rdy_val : ($urandom_range(0, 3) != 0);
        if (rsp_valid) rsp_hi++;
        if (!rst && rsp_valid && rsp_ready) begin
            if (expq.size() == 0) begin
                check_eq("rsp_unexpected", 32'({rsp_wr, rsp_addr, rsp_data}), 32'hFFFF_FFFF);
            end else begin
                rsp_t e;
                e = expq.pop_front();
                check_eq("rsp_fields", 32'({rsp_wr, rsp_addr, rsp_data}), 32'(e));
                n_rsp++;
            end
        end
    end

    task automatic send(input logic wr, input logic [5:0] a, input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = d;
        while (!req_ready && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            check_eq("req_accept_timeout", 32'(req_ready), 1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        n_acc++;
        if (wr) begin
            ref_mem[a] = d;
            if (ACK) expq.push_back({1'b1, a, d});
        end else begin
            expq.push_back({1'b0, a, ref_mem[a]});
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int t = 0;
        while ((expq.size() != 0 || busy || e_phase != 0) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check_eq(tag, 32'(expq.size() != 0 || busy || e_phase != 0), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 1);
        check_eq({tag, "_rsp"}, 32'({rsp_valid, rsp_wr, rsp_addr, rsp_data}), 0);
        check_eq({tag, "_mem_cmd"}, 32'({mem_wr_en, mem_addr, mem_wr_data}), 0);
        check_eq({tag, "_mem_en"}, 32'(mem_en), 0);
        check_eq({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0, a0, t, nm;
        rst = 1'b1; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 64; i++) begin
            emem[i]    = 8'($urandom);
            ref_mem[i] = emem[i];
        end
        repeat (3) @(posedge clk);
        #1 check_reset_outputs("reset");
        @(negedge clk) rst = 1'b0;

        // single read
        emem[6'h15] = 8'hA5; ref_mem[6'h15] = 8'hA5;
        rsp_hi = 0; n0 = n_rsp;
        send(1'b0, 6'h15, 8'h00);
        wait_idle("single_read_drain");
        check_eq("single_read_pulse_cycles", 32'(rsp_hi), 1);
        check_eq("single_read_rsp_count", 32'(n_rsp - n0), 1);
        check_eq("single_read_cmd", 32'({e_wr, e_addr}), 32'({1'b0, 6'h15}));

        // write then read-back
        n0 = n_rsp;
        send(1'b1, 6'h3F, 8'hC3);
        send(1'b0, 6'h3F, 8'h00);
        wait_idle("wr_rd_drain");
        check_eq("wr_rd_mem", 32'(emem[6'h3F]), 32'h0C3);
        check_eq("wr_rd_rsp_count", 32'(n_rsp - n0), ACK ? 2 : 1);

        // FIFO full under response backpressure
        rdy_val = 1'b0; a0 = n_acc; n0 = n_rsp;
        fork
            begin
                for (int i = 0; i < 6; i++) send(1'b0, 6'($urandom), 8'h00);
            end
            begin
                t = 0;
                @(negedge clk);
                while (req_ready && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                check_eq("full_accepted_at_fall", 32'(n_acc - a0), 5);
                repeat (10) @(negedge clk);
                check_eq("full_ready_held_low", 32'(req_ready), 0);
                check_eq("full_no_extra_accept", 32'(n_acc - a0), 5);
                check_eq("full_rsp_waiting", 32'(rsp_valid), 1);
                rdy_val = 1'b1;
            end
        join
        wait_idle("full_drain");
        check_eq("full_rsp_count", 32'(n_rsp - n0), 6);

        // slow mem_valid release
        fall_lo = 5; fall_hi = 5;
        for (int i = 0; i < 5; i++) send(1'($urandom), 6'($urandom), 8'($urandom));
        wait_idle("slow_release_drain");
        fall_lo = 0; fall_hi = 2;

        // reset during S_ISSUE with two entries queued
        lat_lo = 8; lat_hi = 8;
        for (int i = 0; i < 3; i++) send(1'b0, 6'(i + 40), 8'h00);
        t = 0;
        while (!(mem_en && !mem_valid) && t < 50) begin
            @(negedge clk);
            t++;
        end
        check_eq("mid_reset_in_issue", 32'(mem_en && !mem_valid), 1);
        rst = 1'b1;
        expq.delete();
        @(posedge clk);
        #1 check_reset_outputs("mid_reset");
        @(negedge clk) rst = 1'b0;
        rsp_hi = 0;
        repeat (15) @(negedge clk);
        check_eq("mid_reset_no_rsp", 32'(rsp_hi), 0);
        check_eq("mid_reset_idle", 32'({busy, mem_en}), 0);
        lat_lo = 1; lat_hi = 3;

        // pointer wrap: 20 sequential reads
        n0 = n_rsp;
        for (int i = 0; i < 20; i++) send(1'b0, 6'(i), 8'h00);
        wait_idle("wrap_drain");
        check_eq("wrap_rsp_count", 32'(n_rsp - n0), 20);

        // randomized traffic with random response backpressure
        rdy_force = 1'b0;
        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            send(1'($urandom), 6'($urandom_range(0, 15)), 8'($urandom));
        end
        wait_idle("random_drain");
        rdy_force = 1'b1;

        nm = 0;
        for (int i = 0; i < 64; i++) if (emem[i] !== ref_mem[i]) nm++;
        check_eq("mem_image_mismatches", 32'(nm), 0);
        check_eq("final_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
